// File: rtl/reg_file_wr_arb.sv
// Round-robin write-back arbiter in front of the register file.
// Writes to r0 are accepted and counted, but they are never forwarded to the register file.
package reg_file_pkg;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_file_wr_req_pkt_t;
endpackage

module reg_file_wr_arb
  import reg_file_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DROP_CNT_W = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                 [NUM_REQ-1:0]  req_vld,
  input  reg_file_wr_req_pkt_t [NUM_REQ-1:0]  req_pkt,
  output logic                 [NUM_REQ-1:0]  req_rdy,
  output logic                                reg_file_wr_req_vld,
  output reg_file_wr_req_pkt_t                reg_file_wr_req_pkt,
  output logic                 [DROP_CNT_W-1:0] drop_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: requester i transfers in a cycle where req_vld[i] && req_rdy[i]. It must hold
  // req_vld and req_pkt stable until then. req_rdy is one-hot or zero and only follows req_vld.
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     nxt_ptr;
  logic [PTR_W:0]       sum;
  logic                 found;
  logic                 xfer;
  reg_file_wr_req_pkt_t win_pkt;

  // The first valid requester at or after rr_ptr wins, searching upward with wrap.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!found && req_vld[sum[PTR_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (found && resetn) req_rdy[gnt_idx] = 1'b1;
  end

  assign xfer    = |req_rdy;
  assign win_pkt = req_pkt[gnt_idx];
  assign nxt_ptr = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr              <= '0;
      reg_file_wr_req_vld <= 1'b0;
      reg_file_wr_req_pkt <= '0;
      drop_cnt            <= '0;
    end else begin
      reg_file_wr_req_vld <= 1'b0;
      if (xfer) begin
        rr_ptr <= nxt_ptr;
        if (win_pkt.addr != 5'd0) begin
          reg_file_wr_req_vld <= 1'b1;
          reg_file_wr_req_pkt <= win_pkt;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Directed bench for reg_file_wr_arb: the driver pushes the expected write-backs into a queue.
// A separate negedge monitor pops that queue and compares each strobe against it.
module tb_reg_file_wr_arb;
  import reg_file_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int DCW     = 16;

  logic                                clk;
  logic                                resetn;
  logic                 [NUM_REQ-1:0]  req_vld;
  reg_file_wr_req_pkt_t [NUM_REQ-1:0]  req_pkt;
  logic                 [NUM_REQ-1:0]  req_rdy;
  logic                                out_vld;
  reg_file_wr_req_pkt_t                out_pkt;
  logic                 [DCW-1:0]      drop_cnt;

  reg_file_wr_arb #(.NUM_REQ(NUM_REQ), .DROP_CNT_W(DCW)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .req_vld             (req_vld),
    .req_pkt             (req_pkt),
    .req_rdy             (req_rdy),
    .reg_file_wr_req_vld (out_vld),
    .reg_file_wr_req_pkt (out_pkt),
    .drop_cnt            (drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [36:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] ref_rf[32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic reg_file_wr_req_pkt_t mk(input logic [4:0] a, input logic [31:0] d);
    reg_file_wr_req_pkt_t p;
    p.addr = a;
    p.data = d;
    return p;
  endfunction

  // monitor: every strobe must match the head of the expected queue, exactly one cycle after its grant
  always @(negedge clk) begin
    if (resetn && out_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {27'd0, out_pkt}, 64'd0);
      end else begin
        logic [36:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("strobe_pkt", {27'd0, out_pkt}, {27'd0, e});
        chk("strobe_latency", 64'(cyc), 64'(ec + 1));
        ref_rf[out_pkt.addr] = out_pkt.data;
      end
    end
  end

  // driver: one cycle of stimulus plus the hand-computed expected grant
  task automatic step(input string name, input logic [2:0] vld,
                      input reg_file_wr_req_pkt_t p0, input reg_file_wr_req_pkt_t p1,
                      input reg_file_wr_req_pkt_t p2, input logic [2:0] exp_rdy);
    reg_file_wr_req_pkt_t pk[3];
    @(posedge clk); #1;
    req_vld    = vld;
    req_pkt[0] = p0;
    req_pkt[1] = p1;
    req_pkt[2] = p2;
    pk[0] = p0; pk[1] = p1; pk[2] = p2;
    @(negedge clk);
    chk(name, 64'(req_rdy), 64'(exp_rdy));
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i] && pk[i].addr != 5'd0) begin
        exp_q.push_back(pk[i]);
        exp_cyc_q.push_back(cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle_rdy", 3'b000, '0, '0, '0, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    req_vld = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  reg_file_wr_req_pkt_t z;

  initial begin
    z       = '0;
    resetn  = 1'b0;
    req_vld = 3'b111;
    req_pkt = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;

    // reset state, with all requesters asserting valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_pkt", {27'd0, out_pkt}, 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    req_vld = '0;
    resetn  = 1'b1;

    // single request from requester 0
    step("single_rdy", 3'b001, mk(5'd5, 32'hDEADBEEF), z, z, 3'b001);
    idle(2);

    // r0 write from requester 1 (rr_ptr is 1): dropped, then rr_ptr must sit at 2
    step("r0_rdy", 3'b010, z, mk(5'd0, 32'h1234), z, 3'b010);
    @(negedge clk);
    chk("r0_drop", 64'(drop_cnt), 64'd1);
    step("ptr_at_2", 3'b111, mk(5'd1, 32'h11), mk(5'd2, 32'h22), mk(5'd3, 32'h33), 3'b100);
    idle(1);

    // all three held valid after reset: grants 0,1,2,0,1,2
    do_reset();
    step("rr_g0", 3'b111, mk(5'd1, 32'hA0), mk(5'd2, 32'hB0), mk(5'd3, 32'hC0), 3'b001);
    step("rr_g1", 3'b111, mk(5'd4, 32'hA1), mk(5'd2, 32'hB0), mk(5'd3, 32'hC0), 3'b010);
    step("rr_g2", 3'b111, mk(5'd4, 32'hA1), mk(5'd5, 32'hB1), mk(5'd3, 32'hC0), 3'b100);
    step("rr_g3", 3'b111, mk(5'd4, 32'hA1), mk(5'd5, 32'hB1), mk(5'd6, 32'hC1), 3'b001);
    step("rr_g4", 3'b111, mk(5'd8, 32'hA2), mk(5'd5, 32'hB1), mk(5'd6, 32'hC1), 3'b010);
    step("rr_g5", 3'b111, mk(5'd8, 32'hA2), mk(5'd9, 32'hB2), mk(5'd6, 32'hC1), 3'b100);
    idle(2);

    // same-address collision with rr_ptr at 2: 0xB is written first, then 0xA
    step("col_pre", 3'b010, z, mk(5'd9, 32'h99), z, 3'b010);
    step("col_g2", 3'b101, mk(5'd7, 32'hA), z, mk(5'd7, 32'hB), 3'b100);
    step("col_g0", 3'b001, mk(5'd7, 32'hA), z, z, 3'b001);
    idle(2);
    chk("col_ref_r7", 64'(ref_rf[7]), 64'hA);

    // reset pulsed between a grant and its output edge: the strobe is discarded
    @(posedge clk); #1;
    req_vld    = 3'b001;
    req_pkt[0] = mk(5'd4, 32'hCAFE);
    @(negedge clk);
    chk("mid_rdy", 64'(req_rdy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_rdy", 64'(req_rdy), 64'd0);
    chk("mid_rst_vld", 64'(out_vld), 64'd0);
    req_vld = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_hold_vld", 64'(out_vld), 64'd0);
    resetn = 1'b1;
    step("post_rst_g1", 3'b110, z, mk(5'd10, 32'h10), mk(5'd11, 32'h11), 3'b010);
    step("post_rst_g2", 3'b100, z, z, mk(5'd11, 32'h11), 3'b100);
    idle(2);

    // drop counter saturation over 2^16+3 r0 writes
    chk("sat_start", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    req_vld = 3'b111;
    req_pkt = '0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_pre", 64'(drop_cnt), 64'hFFFE);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sat_max", 64'(drop_cnt), 64'hFFFF);
    req_vld = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);

    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
